// File: rtl/cache_pkg.sv
// Shared types for the cache set replacement logic: way/age indices and the LRU engine FSM states.
package cache_pkg;

    localparam int unsigned NumWaysDflt = 4;
    localparam int unsigned WayIdxW     = $clog2(NumWaysDflt);

    typedef logic [WayIdxW-1:0] way_idx_t;
    typedef logic [WayIdxW-1:0] age_t;

    typedef enum logic [1:0] {
        StIdle,
        StSelect,
        StWaitFill
    } state_e;

endpackage

// File: rtl/lru_victim_select.sv
// Combinational victim picker: the LRU way, or with EVICT_INVALID_FIRST_EN the lowest invalid way.
module lru_victim_select #(
    parameter int unsigned NUM_WAYS      = 4,
    parameter int unsigned COUNTER_WIDTH = $clog2(NUM_WAYS)
) (
    input  logic [NUM_WAYS*COUNTER_WIDTH-1:0] ages_i,
    input  logic [NUM_WAYS-1:0]               way_valid_i,
    output logic [$clog2(NUM_WAYS)-1:0]       victim_o
);

    localparam int unsigned IdxW = $clog2(NUM_WAYS);

    logic [IdxW-1:0] lru_way;

    always_comb begin
        lru_way = '0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (ages_i[i*COUNTER_WIDTH +: COUNTER_WIDTH] == COUNTER_WIDTH'(NUM_WAYS - 1)) begin
                lru_way = IdxW'(i);
            end
        end
    end

`ifdef EVICT_INVALID_FIRST_EN
    logic [IdxW-1:0] inv_way;

    // Scan high to low so the lowest-index invalid way wins.
    always_comb begin
        inv_way = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (!way_valid_i[i]) begin
                inv_way = IdxW'(i);
            end
        end
    end

    assign victim_o = (&way_valid_i) ? lru_way : inv_way;
`else
    logic unused_way_valid;

    assign unused_way_valid = ^way_valid_i;
    assign victim_o         = lru_way;
`endif

endmodule

// File: rtl/lru_eviction_policy.sv
// Counter-based true-LRU replacement engine for one cache set; optional EVICT_INVALID_FIRST_EN
// makes the victim picker prefer invalid ways.
module lru_eviction_policy
    import cache_pkg::*;
#(
    parameter int unsigned NUM_WAYS      = 4,
    parameter int unsigned COUNTER_WIDTH = $clog2(NUM_WAYS)
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        access_valid,
    input  logic [$clog2(NUM_WAYS)-1:0] access_way,
    input  logic [NUM_WAYS-1:0]         way_valid,
    input  logic                        victim_req,
    input  logic                        fill_done,
    output logic                        victim_valid,
    output logic [$clog2(NUM_WAYS)-1:0] victim_way,
    output logic                        busy,
    output logic                        access_drop
);

    localparam int unsigned IdxW = $clog2(NUM_WAYS);

    state_e                   state_q, state_d;
    logic [COUNTER_WIDTH-1:0] age_q [NUM_WAYS];
    logic [COUNTER_WIDTH-1:0] age_d [NUM_WAYS];
    logic [IdxW-1:0]          victim_way_q, victim_way_d;
    logic                     victim_valid_q, victim_valid_d;
    logic                     access_drop_q, access_drop_d;

    logic                     touch_en;
    logic [IdxW-1:0]          touch_way;
    logic [COUNTER_WIDTH-1:0] touch_age;
    logic [NUM_WAYS*COUNTER_WIDTH-1:0] ages_flat;
    logic [IdxW-1:0]          sel_way;

    always_comb begin
        for (int i = 0; i < NUM_WAYS; i++) begin
            ages_flat[i*COUNTER_WIDTH +: COUNTER_WIDTH] = age_q[i];
        end
    end

    lru_victim_select #(
        .NUM_WAYS      (NUM_WAYS),
        .COUNTER_WIDTH (COUNTER_WIDTH)
    ) u_victim_select (
        .ages_i      (ages_flat),
        .way_valid_i (way_valid),
        .victim_o    (sel_way)
    );

    always_comb begin
        state_d        = state_q;
        victim_way_d   = victim_way_q;
        victim_valid_d = victim_valid_q;
        access_drop_d  = access_drop_q;
        touch_en       = 1'b0;
        touch_way      = '0;

        unique case (state_q)
            StIdle: begin
                // The touch lands in age_d, so SELECT next cycle sees post-touch ages.
                if (access_valid) begin
                    touch_en  = 1'b1;
                    touch_way = access_way;
                end
                if (victim_req) begin
                    state_d = StSelect;
                end
            end
            StSelect: begin
                victim_way_d   = sel_way;
                victim_valid_d = 1'b1;
                state_d        = StWaitFill;
                if (access_valid) begin
                    access_drop_d = 1'b1;
                end
            end
            StWaitFill: begin
                if (access_valid) begin
                    access_drop_d = 1'b1;
                end
                if (fill_done) begin
                    touch_en       = 1'b1;
                    touch_way      = victim_way_q;
                    victim_valid_d = 1'b0;
                    state_d        = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Touch: younger ways age by one, the touched way becomes MRU, older ways keep their age.
    always_comb begin
        touch_age = age_q[touch_way];
        for (int i = 0; i < NUM_WAYS; i++) begin
            age_d[i] = age_q[i];
            if (touch_en) begin
                if (IdxW'(i) == touch_way) begin
                    age_d[i] = '0;
                end else if (age_q[i] < touch_age) begin
                    age_d[i] = age_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            victim_way_q   <= '0;
            victim_valid_q <= 1'b0;
            access_drop_q  <= 1'b0;
            for (int i = 0; i < NUM_WAYS; i++) begin
                age_q[i] <= COUNTER_WIDTH'(i);
            end
        end else begin
            state_q        <= state_d;
            victim_way_q   <= victim_way_d;
            victim_valid_q <= victim_valid_d;
            access_drop_q  <= access_drop_d;
            for (int i = 0; i < NUM_WAYS; i++) begin
                age_q[i] <= age_d[i];
            end
        end
    end

    assign victim_valid = victim_valid_q;
    assign victim_way   = victim_way_q;
    assign busy         = (state_q != StIdle);
    assign access_drop  = access_drop_q;

endmodule

// File: tb/tb_lru_eviction_policy.sv
// Self-checking bench for lru_eviction_policy: directed scenarios plus randomized traffic against
// a recency-list reference model.
module tb_lru_eviction_policy;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       access_valid;
    logic [1:0] access_way;
    logic [3:0] way_valid;
    logic       victim_req;
    logic       fill_done;
    logic       victim_valid;
    logic [1:0] victim_way;
    logic       busy;
    logic       access_drop;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: order[0] is MRU, last entry is LRU.
    int order[$];
    int m_state;
    int m_vic;
    bit m_valid;
    bit m_drop;

    always #5 clk = ~clk;

    lru_eviction_policy #(
        .NUM_WAYS      (4),
        .COUNTER_WIDTH (2)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .access_valid (access_valid),
        .access_way   (access_way),
        .way_valid    (way_valid),
        .victim_req   (victim_req),
        .fill_done    (fill_done),
        .victim_valid (victim_valid),
        .victim_way   (victim_way),
        .busy         (busy),
        .access_drop  (access_drop)
    );

    function automatic void m_reset();
        order   = {0, 1, 2, 3};
        m_state = 0;
        m_vic   = 0;
        m_valid = 1'b0;
        m_drop  = 1'b0;
    endfunction

    function automatic void m_touch(input int w);
        for (int i = 0; i < order.size(); i++) begin
            if (order[i] == w) begin
                order.delete(i);
                break;
            end
        end
        order.push_front(w);
    endfunction

    function automatic int m_pick(input logic [3:0] wv);
`ifdef EVICT_INVALID_FIRST_EN
        for (int i = 0; i < 4; i++) begin
            if (!wv[i]) return i;
        end
`endif
        return order[order.size()-1];
    endfunction

    // Drive one cycle of inputs, advance the model at the edge, return 1 time unit later.
    task automatic cycle(input bit av, input int aw, input bit vr, input bit fd,
                         input logic [3:0] wv);
        logic [1:0] awb;
        awb          = aw[1:0];
        access_valid = av;
        access_way   = awb;
        victim_req   = vr;
        fill_done    = fd;
        way_valid    = wv;
        @(posedge clk);
        case (m_state)
            0: begin
                if (av) m_touch(aw);
                if (vr) m_state = 1;
            end
            1: begin
                m_vic   = m_pick(wv);
                m_valid = 1'b1;
                m_state = 2;
                if (av) m_drop = 1'b1;
            end
            default: begin
                if (av) m_drop = 1'b1;
                if (fd) begin
                    m_touch(m_vic);
                    m_valid = 1'b0;
                    m_state = 0;
                end
            end
        endcase
        #1;
        access_valid = 1'b0;
        victim_req   = 1'b0;
        fill_done    = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        m_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (victim_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", victim_valid);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy);
        else n_pass++;
        n_checks++;
        if (access_drop !== 1'b0) $display("FAIL reset_drop got %0b want 0", access_drop);
        else n_pass++;
        n_checks++;
        if (victim_way !== 2'd0) $display("FAIL reset_way got %0d want 0", victim_way);
        else n_pass++;
    endtask

    task automatic test_victim_basic();
        do_reset();
        cycle(0, 0, 1, 0, 4'hF);
        n_checks++;
        if (busy !== 1'b1 || victim_valid !== 1'b0)
            $display("FAIL basic_select got busy=%0b valid=%0b want busy=1 valid=0",
                     busy, victim_valid);
        else n_pass++;
        cycle(0, 0, 0, 0, 4'hF);
        n_checks++;
        if (victim_valid !== 1'b1 || victim_way !== 2'd3 || busy !== 1'b1)
            $display("FAIL basic_victim got valid=%0b way=%0d busy=%0b want 1/3/1",
                     victim_valid, victim_way, busy);
        else n_pass++;
    endtask

    // Continues from test_victim_basic: WAIT_FILL with victim 3.
    task automatic test_fill();
        cycle(0, 0, 0, 1, 4'hF);
        n_checks++;
        if (victim_valid !== 1'b0 || busy !== 1'b0 || victim_way !== 2'd3)
            $display("FAIL fill_done got valid=%0b busy=%0b way=%0d want 0/0/3",
                     victim_valid, busy, victim_way);
        else n_pass++;
        cycle(0, 0, 1, 0, 4'hF);
        cycle(0, 0, 0, 0, 4'hF);
        n_checks++;
        if (victim_valid !== 1'b1 || victim_way !== 2'd2)
            $display("FAIL fill_next got valid=%0b way=%0d want 1/2", victim_valid, victim_way);
        else n_pass++;
        cycle(0, 0, 0, 1, 4'hF);
    endtask

    task automatic test_touch_order();
        do_reset();
        cycle(1, 3, 0, 0, 4'hF);
        cycle(1, 2, 0, 0, 4'hF);
        cycle(0, 0, 1, 0, 4'hF);
        cycle(0, 0, 0, 0, 4'hF);
        n_checks++;
        if (victim_way !== 2'd1) $display("FAIL touch_victim got %0d want 1", victim_way);
        else n_pass++;
        cycle(0, 0, 0, 1, 4'hF);
        // Same-cycle touch and request: SELECT must see the post-touch ages.
        cycle(1, 0, 1, 0, 4'hF);
        cycle(0, 0, 0, 0, 4'hF);
        n_checks++;
        if (victim_way !== 2'd3) $display("FAIL touch_same_cycle got %0d want 3", victim_way);
        else n_pass++;
        cycle(0, 0, 0, 1, 4'hF);
    endtask

    task automatic test_invalid_first();
        int exp_way;
`ifdef EVICT_INVALID_FIRST_EN
        exp_way = 2;
`else
        exp_way = 3;
`endif
        do_reset();
        cycle(0, 0, 1, 0, 4'b1011);
        cycle(0, 0, 0, 0, 4'b1011);
        n_checks++;
        if (victim_way !== 2'(exp_way))
            $display("FAIL invalid_first got %0d want %0d", victim_way, exp_way);
        else n_pass++;
        cycle(0, 0, 0, 1, 4'hF);
    endtask

    task automatic test_access_drop();
        do_reset();
        cycle(1, 3, 0, 0, 4'hF);
        cycle(0, 0, 1, 0, 4'hF);
        cycle(0, 0, 0, 0, 4'hF);
        cycle(1, 0, 0, 0, 4'hF);
        n_checks++;
        if (access_drop !== 1'b1 || victim_way !== 2'd2)
            $display("FAIL drop_set got drop=%0b way=%0d want 1/2", access_drop, victim_way);
        else n_pass++;
        cycle(0, 0, 0, 1, 4'hF);
        cycle(0, 0, 1, 0, 4'hF);
        cycle(0, 0, 0, 0, 4'hF);
        n_checks++;
        if (victim_way !== 2'd1) $display("FAIL drop_second got %0d want 1", victim_way);
        else n_pass++;
        cycle(0, 0, 0, 1, 4'hF);
        cycle(0, 0, 1, 0, 4'hF);
        cycle(0, 0, 0, 0, 4'hF);
        n_checks++;
        if (victim_way !== 2'd0 || access_drop !== 1'b1)
            $display("FAIL drop_ignored got way=%0d drop=%0b want 0/1", victim_way, access_drop);
        else n_pass++;
        cycle(0, 0, 0, 1, 4'hF);
    endtask

    task automatic test_reset_wait_fill();
        do_reset();
        cycle(1, 1, 1, 0, 4'hF);
        cycle(0, 0, 0, 0, 4'hF);
        cycle(1, 2, 0, 0, 4'hF);
        #2;
        reset_n = 1'b0;
        m_reset();
        #1;
        n_checks++;
        if (victim_valid !== 1'b0 || busy !== 1'b0 || access_drop !== 1'b0)
            $display("FAIL rst_async got valid=%0b busy=%0b drop=%0b want 0/0/0",
                     victim_valid, busy, access_drop);
        else n_pass++;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cycle(0, 0, 1, 0, 4'hF);
        cycle(0, 0, 0, 0, 4'hF);
        n_checks++;
        if (victim_valid !== 1'b1 || victim_way !== 2'd3)
            $display("FAIL rst_after got valid=%0b way=%0d want 1/3", victim_valid, victim_way);
        else n_pass++;
        cycle(0, 0, 0, 1, 4'hF);
    endtask

    task automatic test_random();
        bit         av, vr, fd;
        int         aw;
        logic [3:0] wv;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            av = ($urandom % 3) == 0;
            aw = $urandom % 4;
            vr = ($urandom % 3) == 0;
            fd = (m_state == 2) ? ($urandom % 2) : (($urandom % 8) == 0);
            wv = (($urandom % 3) == 0) ? 4'($urandom) : 4'hF;
            cycle(av, aw, vr, fd, wv);
            n_checks++;
            if (victim_valid !== m_valid || busy !== (m_state != 0) ||
                access_drop !== m_drop || victim_way !== 2'(m_vic))
                $display("FAIL rand_c%0d got v=%0b b=%0b d=%0b w=%0d want v=%0b b=%0b d=%0b w=%0d",
                         n, victim_valid, busy, access_drop, victim_way,
                         m_valid, (m_state != 0), m_drop, m_vic);
            else n_pass++;
        end
    endtask

    initial begin
        reset_n      = 1'b0;
        access_valid = 1'b0;
        access_way   = '0;
        way_valid    = 4'hF;
        victim_req   = 1'b0;
        fill_done    = 1'b0;
        m_reset();
        test_reset();
        test_victim_basic();
        test_fill();
        test_touch_order();
        test_invalid_first();
        test_access_drop();
        test_reset_wait_fill();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lru_eviction_policy.md
# lru_eviction_policy

Counter-based true-LRU replacement engine for one set of the cache. It sits beside the way array in the cache controller: it consumes hit/touch events and per-way valid bits, and on a miss request it produces a registered victim way index that the refill path uses to overwrite a way. The victim is held stable until the refill completes, then promoted to most-recently-used.

## Interface
- NUM_WAYS, 4, number of ways; power of two, ≥ 2
- COUNTER_WIDTH, $clog2(NUM_WAYS), width of each per-way age counter; must be ≥ $clog2(NUM_WAYS)

- clk  in  1  single clock; all state changes on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- access_valid  in  1  hit/touch of access_way this cycle
- access_way  in  $clog2(NUM_WAYS)  way touched
- way_valid  in  NUM_WAYS  per-way valid bits from the ways
- victim_req  in  1  miss: request a victim
- fill_done  in  1  refill of the current victim complete (1-cycle pulse)
- victim_valid  out  1  victim_way is valid and stable
- victim_way  out  $clog2(NUM_WAYS)  selected victim
- busy  out  1  state ≠ IDLE
- access_drop  out  1  sticky: an access_valid arrived outside IDLE

## Operation
- Ages: one counter per way; 0 = MRU, NUM_WAYS-1 = LRU; ages always form a permutation of 0..NUM_WAYS-1
- Reset: age[i] = i; state IDLE; all outputs 0
- Touch of way w (age a): every way with age < a increments; age[w] ← 0; ways with age > a unchanged
- FSM states: IDLE, SELECT, WAIT_FILL
- IDLE: access_valid → touch access_way. victim_req → SELECT. Both in same cycle: touch applied first, SELECT sees post-touch ages
- SELECT: compute victim from current ages and way_valid, register into victim_way, set victim_valid → WAIT_FILL
- WAIT_FILL: victim_way/victim_valid held stable; fill_done → touch victim_way, clear victim_valid → IDLE
- access_valid in SELECT or WAIT_FILL: ignored (ages unchanged), access_drop ← 1 (cleared only by reset)
- victim_req outside IDLE: ignored. fill_done outside WAIT_FILL: ignored
- Victim rule: way with age NUM_WAYS-1 (subject to Configuration)

## Timing
- victim_req sampled at edge ending cycle N → SELECT in N+1 → victim_valid=1 and victim_way valid from N+2 (2-cycle latency)
- fill_done sampled in cycle M (WAIT_FILL, including the first cycle victim_valid is high) → victim_valid=0, busy=0, victim MRU from M+1
- Touch in IDLE visible in ages the next cycle
- victim_way retains last value after victim_valid drops
- reset_n asserted in any state (incl. WAIT_FILL): outputs and ages return to reset values immediately, no pending fill remembered

## Configuration
- EVICT_INVALID_FIRST_EN defined: in SELECT, if any way_valid bit is 0, victim = lowest-index invalid way; otherwise LRU way
- Not defined: way_valid is ignored; victim is always the LRU way

## Structure
- Shared package cache_pkg: way index typedef ($clog2(NUM_WAYS) bits), age typedef, FSM state enum (IDLE, SELECT, WAIT_FILL)
- Sub-module lru_victim_select: combinational; ages + way_valid → victim index; contains the EVICT_INVALID_FIRST_EN selection

## Test plan
- Reset, way_valid=4'b1111, victim_req → victim_way=3, victim_valid=1 two cycles later, busy=1
- Touch 3 then touch 2, then victim_req → ages {0:2,1:3,2:0,3:1}, victim_way=1
- After case 1 victim 3, fill_done → victim_valid=0 next cycle; victim_req → victim_way=2
- EVICT_INVALID_FIRST_EN, way_valid=4'b1011, victim_req → victim_way=2; without macro → victim_way=3
- access_valid for way 0 during WAIT_FILL → access_drop=1, after fill_done way 0 remains at pre-access age
- reset_n low during WAIT_FILL → victim_valid=0, busy=0, access_drop=0; next victim_req → victim_way=3
